// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU fetch definitions: fetch FSM encoding, datapath widths and the PC increment.
package pc_fetch_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned JT_W  = 26;

  localparam logic [XLEN-1:0] PC_INC = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_next_pc_mux.sv
// Next-PC selection: register jump over J/JAL over taken branch over fall-through.
module next_pc_mux
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  output logic [31:0] next_pc_c
);

  logic [31:0] jr_pc;
  logic [31:0] jump_pc;
  logic [31:0] branch_pc;

  // Word offset scaled to bytes; the top two offset bits fall off modulo 2^32.
  assign jr_pc     = {jr_addr[31:2], 2'b00};
  assign jump_pc   = {pc_plus4[31:28], jump_target, 2'b00};
  assign branch_pc = pc_plus4 + {branch_offset[29:0], 2'b00};

  always_comb begin
    next_pc_c = pc_plus4;
    if (jr) begin
      next_pc_c = jr_pc;
    end else if (jump) begin
      next_pc_c = jump_pc;
    end else if (branch_taken) begin
      next_pc_c = branch_pc;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: issues one word read per instruction, holds it for decode, then redirects.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         armed_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  next_pc_c;

  logic         imem_req_d;
  logic [31:0]  imem_addr_d;
  logic [31:0]  inst_d;
  logic [31:0]  inst_pc_d;
  logic [31:0]  pc_plus4_d;
  logic         inst_valid_d;

  next_pc_mux u_next_pc_mux (
    .pc_plus4      (pc_plus4),
    .jr            (jr),
    .jr_addr       (jr_addr),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .next_pc_c     (next_pc_c)
  );

  // armed_q keeps IDLE for one full cycle after the first cycle rst_n is seen high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (armed_q)   state_d = ST_FETCH;
      ST_FETCH: if (imem_ack)  state_d = ST_HOLD;
      ST_HOLD:  if (!stall)    state_d = ST_FETCH;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Next values of every registered output; redirects and acks only matter in their own state.
  always_comb begin
    pc_d         = pc_q;
    inst_d       = inst;
    inst_pc_d    = inst_pc;
    pc_plus4_d   = pc_plus4;
    if ((state_q == ST_HOLD) && !stall) begin
      pc_d = next_pc_c;
    end
    if ((state_q == ST_FETCH) && imem_ack) begin
      inst_d     = imem_rdata;
      inst_pc_d  = pc_q;
      pc_plus4_d = pc_q + PC_INC;
    end
    imem_req_d   = (state_d == ST_FETCH);
    imem_addr_d  = pc_d;
    inst_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
      pc_plus4   <= 32'h0;
      inst_valid <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      imem_req   <= imem_req_d;
      imem_addr  <= imem_addr_d;
      inst       <= inst_d;
      inst_pc    <= inst_pc_d;
      pc_plus4   <= pc_plus4_d;
      inst_valid <= inst_valid_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed corner cases then randomized fetch/redirect traffic.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic [31:0] exp_ipc;
  logic [31:0] exp_pc4;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_addr       (jr_addr),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .pc_plus4      (pc_plus4),
    .inst_valid    (inst_valid)
  );

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference next PC, straight from the redirect rules.
  function automatic logic [31:0] ref_npc(input logic [31:0] pc4, input logic r_jr,
                                          input logic [31:0] r_jra, input logic r_j,
                                          input logic [25:0] r_jt, input logic r_br,
                                          input logic [31:0] r_off);
    logic [63:0] sum;
    if (r_jr) return r_jra & 32'hFFFF_FFFC;
    if (r_j)  return (pc4 & 32'hF000_0000) | ({6'd0, r_jt} * 32'd4);
    if (r_br) begin
      sum = {32'd0, pc4} + ({32'd0, r_off} * 64'd4);
      return sum[31:0];
    end
    return pc4;
  endfunction

  task automatic clear_redirect();
    jr = 1'b0; jr_addr = 32'h0; jump = 1'b0; jump_target = 26'h0;
    branch_taken = 1'b0; branch_offset = 32'h0;
  endtask

  task automatic noise_redirect();
    jr = 1'($urandom); jr_addr = $urandom; jump = 1'($urandom);
    jump_target = 26'($urandom); branch_taken = 1'($urandom); branch_offset = $urandom;
  endtask

  // Expects to be entered just after the edge that raised imem_req.
  task automatic fetch(input int lat);
    chk("req_start", 32'(imem_req), 32'd1);
    chk("addr_start", imem_addr, exp_pc);
    for (int k = 0; k < lat; k++) begin
      noise_redirect();
      imem_ack = 1'b0;
      step();
      chk("req_wait", 32'(imem_req), 32'd1);
      chk("addr_wait", imem_addr, exp_pc);
    end
    clear_redirect();
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    exp_inst   = imem_rdata;
    step();
    imem_ack = 1'b0;
    exp_ipc  = exp_pc;
    exp_pc4  = exp_pc + 32'd4;
    chk("valid_after_ack", 32'(inst_valid), 32'd1);
    chk("req_after_ack", 32'(imem_req), 32'd0);
    chk("inst", inst, exp_inst);
    chk("inst_pc", inst_pc, exp_ipc);
    chk("pc_plus4", pc_plus4, exp_pc4);
  endtask

  task automatic hold(input int stalls, input logic r_jr, input logic [31:0] r_jra,
                      input logic r_j, input logic [25:0] r_jt, input logic r_br,
                      input logic [31:0] r_off);
    for (int k = 0; k < stalls; k++) begin
      stall    = 1'b1;
      imem_ack = 1'($urandom);
      noise_redirect();
      step();
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_inst", inst, exp_inst);
      chk("stall_inst_pc", inst_pc, exp_ipc);
      chk("stall_pc_plus4", pc_plus4, exp_pc4);
    end
    imem_ack = 1'b0;
    stall = 1'b0;
    jr = r_jr; jr_addr = r_jra; jump = r_j; jump_target = r_jt;
    branch_taken = r_br; branch_offset = r_off;
    step();
    clear_redirect();
    exp_pc = ref_npc(exp_pc4, r_jr, r_jra, r_j, r_jt, r_br, r_off);
    chk("consume_valid", 32'(inst_valid), 32'd0);
    chk("next_req", 32'(imem_req), 32'd1);
    chk("next_addr", imem_addr, exp_pc);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    clear_redirect();
    step();
    step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h0);

    // Release: one IDLE cycle, request at RESET_PC on the second edge.
    rst_n = 1'b1;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("idle_req", 32'(imem_req), 32'd0);
    chk("idle_valid", 32'(inst_valid), 32'd0);
    step();
    exp_pc = 32'h0;
    fetch(0);
    hold(0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    fetch(0);
    hold(0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    fetch(1);
    chk("seq_inst_pc_8", inst_pc, 32'h8);

    // Five-cycle stall, then fall through.
    hold(5, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    fetch(2);
    hold(0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    fetch(0);
    chk("br_inst_pc", inst_pc, 32'h10);
    hold(1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFE);
    chk("br_target", imem_addr, 32'h0000_000C);

    // All redirects at once: jr wins and its low bits are cleared.
    fetch(0);
    hold(0, 1'b1, 32'h0000_0103, 1'b1, 26'h3FF_FFFF, 1'b1, 32'h10);
    chk("prio_target", imem_addr, 32'h0000_0100);

    fetch(0);
    hold(0, 1'b1, 32'h4000_0004, 1'b0, 26'h0, 1'b0, 32'h0);
    fetch(0);
    chk("jmp_pc_plus4", pc_plus4, 32'h4000_0008);
    hold(0, 1'b0, 32'h0, 1'b1, 26'h10, 1'b0, 32'h0);
    chk("jmp_target", imem_addr, 32'h4000_0040);

    fetch(0);
    hold(0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0, 1'b0, 32'h0);
    fetch(3);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    hold(0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    chk("wrap_target", imem_addr, 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  sel;
      logic [31:0] off;
      fetch(int'($urandom_range(0, 3)));
      sel = 3'($urandom);
      off = 32'($urandom_range(0, 64)) - 32'd32;
      hold(int'($urandom_range(0, 3)), sel[0] & sel[1], $urandom, sel[1] & sel[2],
           26'($urandom), sel[2] | sel[0], off);
    end

    // Reset while a request waits; the ack that arrives afterwards must be ignored.
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_inst", inst, 32'h0);
    chk("midrst_inst_pc", inst_pc, 32'h0);
    step();
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("late_ack_req", 32'(imem_req), 32'd0);
    chk("late_ack_valid", 32'(inst_valid), 32'd0);
    chk("late_ack_inst", inst, 32'h0);
    step();
    chk("post_rst_valid", 32'(inst_valid), 32'd0);
    exp_pc = 32'h0;
    fetch(1);
    hold(2, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
